// File: rtl/execute_stage.sv
// Execute stage for the 64-bit LEGv8-style datapath: ALU, branch target and store data.
// Combinational by default; define EXECUTE_OUTPUT_REG_EN to register all outputs (1-cycle EX/MEM boundary).
module execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        AluSrc,
    input  logic [3:0]  AluControl,
    input  logic [63:0] PC_E,
    input  logic [63:0] signImm_E,
    input  logic [63:0] readData1_E,
    input  logic [63:0] readData2_E,
    output logic [63:0] PCBranch_E,
    output logic [63:0] aluResult_E,
    output logic [63:0] writeData_E,
    output logic        zero_E
);

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [3:0] ALU_NOR  = 4'b1100;

    logic [63:0] op_b;
    logic [63:0] alu_d;
    logic [63:0] pc_branch_d;
    logic [63:0] write_data_d;
    logic        zero_d;

    assign op_b         = AluSrc ? signImm_E : readData2_E;
    // Offset is in words; bits shifted past bit 63 are simply dropped.
    assign pc_branch_d  = PC_E + {signImm_E[61:0], 2'b00};
    assign write_data_d = readData2_E;

    always_comb begin
        alu_d = 64'd0;
        case (AluControl)
            ALU_AND:  alu_d = readData1_E & op_b;
            ALU_OR:   alu_d = readData1_E | op_b;
            ALU_ADD:  alu_d = readData1_E + op_b;
            ALU_SUB:  alu_d = readData1_E - op_b;
            ALU_PASS: alu_d = op_b;
            ALU_NOR:  alu_d = ~(readData1_E | op_b);
            default:  alu_d = 64'd0;
        endcase
    end

    assign zero_d = (alu_d == 64'd0);

`ifdef EXECUTE_OUTPUT_REG_EN
    logic [63:0] pc_branch_q;
    logic [63:0] alu_q;
    logic [63:0] write_data_q;
    logic        zero_q;

    // zero is registered from the same alu_d so it always agrees with aluResult_E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_branch_q  <= 64'd0;
            alu_q        <= 64'd0;
            write_data_q <= 64'd0;
            zero_q       <= 1'b0;
        end else begin
            pc_branch_q  <= pc_branch_d;
            alu_q        <= alu_d;
            write_data_q <= write_data_d;
            zero_q       <= zero_d;
        end
    end

    assign PCBranch_E  = pc_branch_q;
    assign aluResult_E = alu_q;
    assign writeData_E = write_data_q;
    assign zero_E      = zero_q;
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;

    assign PCBranch_E  = pc_branch_d;
    assign aluResult_E = alu_d;
    assign writeData_E = write_data_d;
    assign zero_E      = zero_d;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; works for both the combinational and registered builds.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        AluSrc;
    logic [3:0]  AluControl;
    logic [63:0] PC_E;
    logic [63:0] signImm_E;
    logic [63:0] readData1_E;
    logic [63:0] readData2_E;
    logic [63:0] PCBranch_E;
    logic [63:0] aluResult_E;
    logic [63:0] writeData_E;
    logic        zero_E;

    int n_checks = 0;
    int n_fail   = 0;

    execute_stage dut (
        .clk         (clk),
        .reset       (reset),
        .AluSrc      (AluSrc),
        .AluControl  (AluControl),
        .PC_E        (PC_E),
        .signImm_E   (signImm_E),
        .readData1_E (readData1_E),
        .readData2_E (readData2_E),
        .PCBranch_E  (PCBranch_E),
        .aluResult_E (aluResult_E),
        .writeData_E (writeData_E),
        .zero_E      (zero_E)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Drive a vector and wait until it is visible on the outputs.
    task automatic apply(input logic src, input logic [3:0] ctl, input logic [63:0] pc,
                         input logic [63:0] imm, input logic [63:0] a, input logic [63:0] b);
        AluSrc      = src;
        AluControl  = ctl;
        PC_E        = pc;
        signImm_E   = imm;
        readData1_E = a;
        readData2_E = b;
`ifdef EXECUTE_OUTPUT_REG_EN
        @(posedge clk);
`endif
        #1;
    endtask

    initial begin
        reset = 1'b1;
        AluSrc = 1'b0; AluControl = 4'b0000; PC_E = 64'd0;
        signImm_E = 64'd0; readData1_E = 64'd0; readData2_E = 64'd0;
        repeat (2) @(posedge clk);
        #3;
`ifdef EXECUTE_OUTPUT_REG_EN
        check("rst_pc",   PCBranch_E,  64'd0);
        check("rst_alu",  aluResult_E, 64'd0);
        check("rst_wd",   writeData_E, 64'd0);
        check("rst_zero", {63'd0, zero_E}, 64'd0);
`endif
        reset = 1'b0;

        apply(1'b0, 4'b0010, 64'h100, 64'd4, 64'd5, 64'd3);
        check("add_pc",   PCBranch_E,  64'h110);
        check("add_res",  aluResult_E, 64'd8);
        check("add_wd",   writeData_E, 64'd3);
        check("add_zero", {63'd0, zero_E}, 64'd0);

        apply(1'b0, 4'b0110, 64'h200, 64'd0, 64'h1234, 64'h1234);
        check("sub_eq_res",  aluResult_E, 64'd0);
        check("sub_eq_zero", {63'd0, zero_E}, 64'd1);
        check("sub_eq_pc",   PCBranch_E, 64'h200);

        apply(1'b1, 4'b0010, 64'h40, 64'hFFFF_FFFF_FFFF_FFFE, 64'd10, 64'd7);
        check("imm_res", aluResult_E, 64'd8);
        check("imm_pc",  PCBranch_E,  64'h38);
        check("imm_wd",  writeData_E, 64'd7);

        apply(1'b0, 4'b0000, 64'd0, 64'd0, 64'hF0F0, 64'h0FF0);
        check("and_res", aluResult_E, 64'h00F0);
        apply(1'b0, 4'b0001, 64'd0, 64'd0, 64'hF0F0, 64'h0FF0);
        check("or_res", aluResult_E, 64'hFFF0);
        apply(1'b0, 4'b1100, 64'd0, 64'd0, 64'hF0F0, 64'h0FF0);
        check("nor_res", aluResult_E, 64'hFFFF_FFFF_FFFF_000F);
        apply(1'b0, 4'b0111, 64'd0, 64'd0, 64'hF0F0, 64'h0FF0);
        check("pass_res",  aluResult_E, 64'h0FF0);
        check("pass_zero", {63'd0, zero_E}, 64'd0);
        // Pass B must follow AluSrc: immediate selected here.
        apply(1'b1, 4'b0111, 64'd0, 64'h55, 64'hF0F0, 64'h0FF0);
        check("pass_imm", aluResult_E, 64'h55);
        check("pass_imm_wd", writeData_E, 64'h0FF0);

        apply(1'b0, 4'b1111, 64'd0, 64'd9, 64'h1234, 64'h5678);
        check("undef_res",  aluResult_E, 64'd0);
        check("undef_zero", {63'd0, zero_E}, 64'd1);
        apply(1'b0, 4'b0011, 64'd0, 64'd9, 64'hFFFF, 64'h1);
        check("undef3_res", aluResult_E, 64'd0);

        apply(1'b0, 4'b0110, 64'd0, 64'd0, 64'd0, 64'd1);
        check("sub_neg_res",  aluResult_E, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub_neg_zero", {63'd0, zero_E}, 64'd0);

        apply(1'b0, 4'b0010, 64'h8, 64'h4000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        check("add_wrap_res",  aluResult_E, 64'd0);
        check("add_wrap_zero", {63'd0, zero_E}, 64'd1);
        check("pc_shift_drop", PCBranch_E, 64'hC);

`ifdef EXECUTE_OUTPUT_REG_EN
        // Mid-cycle reset clears outputs without a clock edge.
        apply(1'b0, 4'b0010, 64'h100, 64'd4, 64'd5, 64'd3);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_pc",   PCBranch_E,  64'd0);
        check("mid_rst_alu",  aluResult_E, 64'd0);
        check("mid_rst_wd",   writeData_E, 64'd0);
        check("mid_rst_zero", {63'd0, zero_E}, 64'd0);
        @(posedge clk);
        #1;
        check("hold_rst_alu", aluResult_E, 64'd0);
        reset = 1'b0;
        AluSrc = 1'b0; AluControl = 4'b0010; PC_E = 64'h100;
        signImm_E = 64'd4; readData1_E = 64'd5; readData2_E = 64'd3;
        #1;
        check("pre_edge_alu", aluResult_E, 64'd0);
        check("pre_edge_pc",  PCBranch_E,  64'd0);
        @(posedge clk);
        #1;
        check("post_edge_alu", aluResult_E, 64'd8);
        check("post_edge_pc",  PCBranch_E,  64'h110);
        check("post_edge_wd",  writeData_E, 64'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
